// File: rtl/am_mag_sequencer_pkg.sv
// rtl/am_mag_sequencer_pkg.sv - shared types and timing helpers for the AM magnitude sequencer
package am_demod_pkg;

    typedef enum logic [2:0] {IDLE, SQ_I, SQ_Q, SQRT, DONE} mag_state_t;

    function automatic int mag_latency(input int width);
        return width + 2;
    endfunction

    function automatic int mag_period(input int width);
        return width + 4;
    endfunction

endpackage

// File: rtl/am_mag_sequencer_if.sv
// rtl/am_mag_sequencer_if.sv - I/Q sample in, magnitude out handshake bundle
interface am_mag_sequencer_if #(parameter int WIDTH = 12);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] i_in;
    logic signed [WIDTH-1:0] q_in;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        mag_out;
    logic                    busy;

    modport master (
        output in_valid, i_in, q_in, out_ready,
        input  in_ready, out_valid, mag_out, busy
    );

    modport slave (
        input  in_valid, i_in, q_in, out_ready,
        output in_ready, out_valid, mag_out, busy
    );
endinterface

// File: rtl/am_mag_sequencer_isqrt_step.sv
// rtl/am_mag_sequencer_isqrt_step.sv - one non-restoring square-root iteration (2 radicand bits in, 1 root bit out)
module isqrt_step #(
    parameter int WIDTH = 12
) (
    input  logic signed [WIDTH+1:0] rem_in,
    input  logic [WIDTH-1:0]        root_in,
    input  logic [1:0]              rad_bits,
    output logic signed [WIDTH+1:0] rem_out,
    output logic [WIDTH-1:0]        root_out
);
    logic signed [WIDTH+1:0] shifted;
    logic signed [WIDTH+1:0] trial;
    logic                    unused_bits;

    // Modular WIDTH+2 arithmetic is exact because the true remainder always fits.
    always_comb begin
        shifted = {rem_in[WIDTH-1:0], rad_bits};
        if (!rem_in[WIDTH+1]) begin
            trial   = {root_in, 2'b01};
            rem_out = shifted - trial;
        end else begin
            trial   = {root_in, 2'b11};
            rem_out = shifted + trial;
        end
        root_out = {root_in[WIDTH-2:0], ~rem_out[WIDTH+1]};
    end

    assign unused_bits = ^{rem_in[WIDTH+1:WIDTH], root_in[WIDTH-1]};
endmodule

// File: rtl/am_mag_sequencer.sv
// rtl/am_mag_sequencer.sv - time-multiplexed floor(sqrt(I^2+Q^2)) engine with one shared multiplier
module am_mag_sequencer
    import am_demod_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  logic              clk,
    input  logic              rst,
    am_mag_sequencer_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    mag_state_t              state_q, state_d;
    logic signed [WIDTH-1:0] i_hold_q, i_hold_d, q_hold_q, q_hold_d;
    logic [2*WIDTH-1:0]      acc_q, acc_d;
    logic signed [WIDTH+1:0] rem_q, rem_d;
    logic [WIDTH-1:0]        root_q, root_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [WIDTH-1:0]        mag_q, mag_d;
    logic                    out_valid_q, out_valid_d;
    logic                    rdy_en_q, rdy_en_d;

    logic                    accept;
    logic                    last_step;
    logic signed [WIDTH-1:0] mul_op;
    logic signed [2*WIDTH-1:0] mul_ext, prod;
    logic signed [WIDTH+1:0] step_rem;
    logic [WIDTH-1:0]        step_root;

    // Single multiplier: squares I in SQ_I, Q in every other state.
    assign mul_op  = (state_q == SQ_I) ? i_hold_q : q_hold_q;
    assign mul_ext = (2*WIDTH)'(mul_op);
    assign prod    = mul_ext * mul_ext;

    assign accept    = bus.in_valid && bus.in_ready;
    assign last_step = (state_q == SQRT) && (cnt_q == CW'(WIDTH - 1));
    assign rdy_en_d  = 1'b1;

    isqrt_step #(.WIDTH(WIDTH)) u_step (
        .rem_in   (rem_q),
        .root_in  (root_q),
        .rad_bits (acc_q[2*WIDTH-1:2*WIDTH-2]),
        .rem_out  (step_rem),
        .root_out (step_root)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SQ_I;
            SQ_I:    state_d = SQ_Q;
            SQ_Q:    state_d = SQRT;
            SQRT:    if (last_step) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = rdy_en_q && (state_q == IDLE);
        bus.busy      = (state_q != IDLE);
        bus.out_valid = out_valid_q;
        bus.mag_out   = mag_q;
    end

    always_comb begin
        i_hold_d    = i_hold_q;
        q_hold_d    = q_hold_q;
        acc_d       = acc_q;
        rem_d       = rem_q;
        root_d      = root_q;
        cnt_d       = cnt_q;
        mag_d       = mag_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: if (accept) begin
                i_hold_d = bus.i_in;
                q_hold_d = bus.q_in;
            end
            SQ_I: acc_d = $unsigned(prod);
            SQ_Q: begin
                acc_d  = acc_q + $unsigned(prod);
                cnt_d  = '0;
                rem_d  = '0;
                root_d = '0;
            end
            SQRT: begin
                acc_d  = acc_q << 2;
                rem_d  = step_rem;
                root_d = step_root;
                cnt_d  = cnt_q + 1'b1;
                if (last_step) begin
                    mag_d       = step_root;
                    out_valid_d = 1'b1;
                end
            end
            DONE: if (bus.out_ready) out_valid_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_hold_q    <= '0;
            q_hold_q    <= '0;
            acc_q       <= '0;
            rem_q       <= '0;
            root_q      <= '0;
            cnt_q       <= '0;
            mag_q       <= '0;
            out_valid_q <= 1'b0;
            rdy_en_q    <= 1'b0;
        end else begin
            i_hold_q    <= i_hold_d;
            q_hold_q    <= q_hold_d;
            acc_q       <= acc_d;
            rem_q       <= rem_d;
            root_q      <= root_d;
            cnt_q       <= cnt_d;
            mag_q       <= mag_d;
            out_valid_q <= out_valid_d;
            rdy_en_q    <= rdy_en_d;
        end
    end
endmodule

// File: tb/tb_am_mag_sequencer.sv
// tb/tb_am_mag_sequencer.sv - self-checking bench for am_mag_sequencer against an arithmetic magnitude model
module tb_am_mag_sequencer;
    localparam int W   = 12;
    localparam int LAT = W + 2;
    localparam int PER = W + 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   errors  = 0;

    am_mag_sequencer_if #(.WIDTH(W)) bus();
    am_mag_sequencer #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.in_ready === 1'b1 && bus.busy === 1'b1) begin
            errors++;
            $display("FAIL ready_busy_overlap in_ready=%0b busy=%0b required not both high", bus.in_ready, bus.busy);
        end
    end

    function automatic int ref_mag(input int i, input int q);
        longint s = longint'(i) * i + longint'(q) * q;
        int     r = int'($floor($sqrt(real'(s))));
        while (longint'(r) * r > s) r--;
        while (longint'(r + 1) * (r + 1) <= s) r++;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int i, input int q, output int lat, output logic [W-1:0] mag);
        int guard = 0;
        bus.i_in     = W'(i);
        bus.q_in     = W'(q);
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && guard < 200) begin
            tick();
            guard++;
        end
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout in_ready=%0b required 1 within 200 cycles", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        bus.i_in     = W'($urandom);
        bus.q_in     = W'($urandom);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        mag = bus.mag_out;
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.i_in      = '0;
        bus.q_in      = '0;
        rst           = 1'b1;
        repeat (3) tick();
        vectors++;
        if ({bus.in_ready, bus.busy, bus.out_valid, bus.mag_out} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got ready=%0b busy=%0b valid=%0b mag=%0d required all 0",
                     bus.in_ready, bus.busy, bus.out_valid, bus.mag_out);
        end
        rst = 1'b0;
        tick();
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got ready=%0b busy=%0b required 1/0", bus.in_ready, bus.busy);
        end
    endtask

    task automatic test_basic();
        int lat;
        logic [W-1:0] mag;
        send(3, 4, lat, mag);
        vectors++;
        if (mag !== W'(5) || lat !== LAT) begin
            errors++;
            $display("FAIL basic_3_4 got mag=%0d lat=%0d required mag=5 lat=%0d", mag, lat, LAT);
        end
        tick();
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.mag_out !== W'(5)) begin
            errors++;
            $display("FAIL basic_pulse got valid=%0b ready=%0b mag=%0d required 0/1/5",
                     bus.out_valid, bus.in_ready, bus.mag_out);
        end
    endtask

    task automatic test_corners();
        int ci[4]  = '{-2048, 2047, 0, -2048};
        int cq[4]  = '{-2048, 0, 0, 0};
        int exp[4] = '{2896, 2047, 0, 2048};
        int lat;
        logic [W-1:0] mag;
        for (int k = 0; k < 4; k++) begin
            send(ci[k], cq[k], lat, mag);
            vectors++;
            if (int'(mag) !== exp[k] || lat !== LAT) begin
                errors++;
                $display("FAIL corner_%0d I=%0d Q=%0d got mag=%0d lat=%0d required mag=%0d lat=%0d",
                         k, ci[k], cq[k], mag, lat, exp[k], LAT);
            end
        end
        tick();
    endtask

    task automatic test_backpressure();
        int lat;
        logic [W-1:0] mag;
        bus.out_ready = 1'b0;
        send(6, 8, lat, mag);
        vectors++;
        if (mag !== W'(10) || lat !== LAT) begin
            errors++;
            $display("FAIL stall_result got mag=%0d lat=%0d required 10/%0d", mag, lat, LAT);
        end
        bus.in_valid = 1'b1;
        bus.i_in     = W'(100);
        bus.q_in     = W'(200);
        for (int c = 0; c < 10; c++) begin
            tick();
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.mag_out !== W'(10) || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d got valid=%0b mag=%0d ready=%0b required 1/10/0",
                         c, bus.out_valid, bus.mag_out, bus.in_ready);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_release got valid=%0b ready=%0b busy=%0b required 0/1/0",
                     bus.out_valid, bus.in_ready, bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        int acc_edge[2];
        int res[$];
        int n   = 0;
        int cyc = 0;
        bit take;
        bus.out_ready = 1'b1;
        bus.i_in      = W'(5);
        bus.q_in      = W'(12);
        bus.in_valid  = 1'b1;
        while (cyc < 60) begin
            take = bus.in_valid && bus.in_ready;
            tick();
            cyc++;
            if (take) begin
                acc_edge[n] = cyc;
                n++;
                if (n == 1) begin
                    bus.i_in = -W'(7);
                    bus.q_in = W'(24);
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            if (bus.out_valid === 1'b1) res.push_back(int'(bus.mag_out));
        end
        vectors++;
        if (n != 2 || res.size() != 2) begin
            errors++;
            $display("FAIL b2b_count got accepts=%0d results=%0d required 2/2", n, res.size());
        end else begin
            vectors++;
            if (res[0] !== 13 || res[1] !== 25 || acc_edge[1] - acc_edge[0] !== PER) begin
                errors++;
                $display("FAIL b2b_values got %0d,%0d spacing=%0d required 13,25 spacing=%0d",
                         res[0], res[1], acc_edge[1] - acc_edge[0], PER);
            end
        end
    endtask

    task automatic test_reset_mid();
        int   guard = 0;
        int   lat;
        bit   saw   = 1'b0;
        logic [W-1:0] mag;
        bus.i_in     = W'(100);
        bus.q_in     = W'(100);
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        tick();
        bus.in_valid = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        #1;
        vectors++;
        if ({bus.in_ready, bus.busy, bus.out_valid, bus.mag_out} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got ready=%0b busy=%0b valid=%0b mag=%0d required all 0",
                     bus.in_ready, bus.busy, bus.out_valid, bus.mag_out);
        end
        repeat (3) tick();
        rst = 1'b0;
        tick();
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_ready got %0b required 1", bus.in_ready);
        end
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.out_valid === 1'b1) saw = 1'b1;
        end
        vectors++;
        if (saw) begin
            errors++;
            $display("FAIL midreset_no_output got out_valid pulse required none");
        end
        send(8, 15, lat, mag);
        vectors++;
        if (mag !== W'(17) || lat !== LAT) begin
            errors++;
            $display("FAIL midreset_after got mag=%0d lat=%0d required 17/%0d", mag, lat, LAT);
        end
        tick();
    endtask

    task automatic test_random(input int n);
        int i, q, lat, stall;
        logic [W-1:0] mag;
        for (int k = 0; k < n; k++) begin
            i = int'($urandom_range(0, 4095)) - 2048;
            q = int'($urandom_range(0, 4095)) - 2048;
            if ($urandom % 16 == 0) i = -2048;
            if ($urandom % 16 == 0) q = ($urandom % 2) ? 2047 : -2048;
            bus.out_ready = ($urandom % 4) != 0;
            send(i, q, lat, mag);
            vectors++;
            if (int'(mag) !== ref_mag(i, q) || lat !== LAT) begin
                errors++;
                $display("FAIL random_%0d I=%0d Q=%0d got mag=%0d lat=%0d required mag=%0d lat=%0d",
                         k, i, q, mag, lat, ref_mag(i, q), LAT);
            end
            if (!bus.out_ready) begin
                stall = $urandom_range(1, 3);
                repeat (stall) tick();
                vectors++;
                if (bus.out_valid !== 1'b1 || bus.mag_out !== mag) begin
                    errors++;
                    $display("FAIL random_stall_%0d got valid=%0b mag=%0d required 1/%0d",
                             k, bus.out_valid, bus.mag_out, mag);
                end
                bus.out_ready = 1'b1;
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random(2500);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
